// File: rtl/c16_mem_pkg.sv
// Shared encodings for the C16 SDRAM command-port arbiter.
package c16_mem_pkg;

  // SDRAM controller command encoding; 2'd3 is reserved and never issued.
  localparam logic [1:0] MEM_RD  = 2'd0;
  localparam logic [1:0] MEM_WR  = 2'd1;
  localparam logic [1:0] MEM_REF = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StAck
  } arb_state_e;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_REF,
    SEL_DL,
    SEL_CPU
  } sel_e;

endpackage

// File: rtl/c16_refresh_timer.sv
// Refresh interval counter plus saturating refresh-debt counter.
module c16_refresh_timer #(
  parameter int unsigned REFRESH_INTERVAL = 390
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       refresh_done,
  output logic [3:0] debt
);

  localparam int unsigned CntW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      debt_q, debt_d;
  logic            wrap;

  // Next-state: wrap adds debt, a completed refresh pays one off; both together cancel.
  always_comb begin
    wrap   = (cnt_q == CntW'(REFRESH_INTERVAL - 1));
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    debt_d = debt_q;
    if (wrap && !refresh_done) begin
      if (debt_q != 4'hf) debt_d = debt_q + 4'd1;
    end else if (refresh_done && !wrap) begin
      if (debt_q != 4'h0) debt_d = debt_q - 4'd1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      debt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      debt_q <= debt_d;
    end
  end

  assign debt = debt_q;

endmodule

// File: rtl/c16_sdram_arb.sv
// Arbitrates the SDRAM controller command port between download, CPU/TED and refresh.
module c16_sdram_arb
  import c16_mem_pkg::*;
#(
  parameter int unsigned ADDR_W           = 25,
  parameter int unsigned REFRESH_INTERVAL = 390,
  parameter int unsigned DEBT_MAX         = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dl_req,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,
  output logic              mem_req,
  output logic [1:0]        mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ready,
  output logic [3:0]        refresh_debt
);

  arb_state_e        state_q, state_d;
  sel_e              sel_q, sel_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic [7:0]        cpu_dout_q, cpu_dout_d;
  logic [3:0]        debt;
  logic              refresh_done;
  logic              debt_urgent;

  assign refresh_done = (state_q == StWait) && (sel_q == SEL_REF) && mem_ready;
  assign debt_urgent  = (32'(debt) >= DEBT_MAX);

  c16_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .refresh_done(refresh_done),
    .debt        (debt)
  );

  // Next-state: priority arbitration in IDLE, then issue / wait / ack sequencing.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    op_d       = op_q;
    addr_d     = addr_q;
    din_d      = din_q;
    cpu_dout_d = cpu_dout_q;
    unique case (state_q)
      StIdle: begin
        if (debt_urgent) begin
          sel_d   = SEL_REF;
          op_d    = MEM_REF;
          addr_d  = '0;
          din_d   = '0;
          state_d = StIssue;
        end else if (dl_req) begin
          sel_d   = SEL_DL;
          op_d    = MEM_WR;
          addr_d  = dl_addr;
          din_d   = dl_data;
          state_d = StIssue;
        end else if (cpu_req) begin
          sel_d   = SEL_CPU;
          op_d    = cpu_we ? MEM_WR : MEM_RD;
          addr_d  = cpu_addr;
          din_d   = cpu_din;
          state_d = StIssue;
        end else if (debt != 4'h0) begin
          sel_d   = SEL_REF;
          op_d    = MEM_REF;
          addr_d  = '0;
          din_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (mem_ready) begin
          if (sel_q == SEL_CPU && op_q == MEM_RD) cpu_dout_d = mem_dout;
          state_d = StAck;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and latched-transaction registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      sel_q      <= SEL_NONE;
      op_q       <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      cpu_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      cpu_dout_q <= cpu_dout_d;
    end
  end

  assign mem_req      = (state_q == StIssue);
  assign dl_ack       = (state_q == StAck) && (sel_q == SEL_DL);
  assign cpu_ack      = (state_q == StAck) && (sel_q == SEL_CPU);
  assign mem_op       = op_q;
  assign mem_addr     = addr_q;
  assign mem_din      = din_q;
  assign cpu_dout     = cpu_dout_q;
  assign refresh_debt = debt;

endmodule

// File: tb/tb_c16_sdram_arb.sv
// Self-checking bench: transaction-level reference model, emulated controller, directed
// scenarios followed by randomized traffic.
module tb_c16_sdram_arb;

  localparam int AW   = 25;
  localparam int RI   = 390;
  localparam int DMAX = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          dl_req, cpu_req, cpu_we;
  logic [AW-1:0] dl_addr, cpu_addr;
  logic [7:0]    dl_data, cpu_din;
  logic          dl_ack, cpu_ack, mem_req;
  logic [7:0]    cpu_dout, mem_din, mem_dout;
  logic [1:0]    mem_op;
  logic [AW-1:0] mem_addr;
  logic          mem_ready;
  logic [3:0]    refresh_debt;

  always #5 clk = ~clk;

  c16_sdram_arb #(
    .ADDR_W          (AW),
    .REFRESH_INTERVAL(RI),
    .DEBT_MAX        (DMAX)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .dl_req      (dl_req),
    .dl_addr     (dl_addr),
    .dl_data     (dl_data),
    .dl_ack      (dl_ack),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_din     (cpu_din),
    .cpu_dout    (cpu_dout),
    .cpu_ack     (cpu_ack),
    .mem_req     (mem_req),
    .mem_op      (mem_op),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout),
    .mem_ready   (mem_ready),
    .refresh_debt(refresh_debt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // who: 0 none, 1 refresh, 2 download, 3 cpu. phase: 0 idle, 1 command, 2 waiting, 3 ack.
  int m_cnt, m_debt, m_phase, m_who, m_op, m_addr, m_din, m_dout;

  task automatic m_reset();
    m_cnt = 0; m_debt = 0; m_phase = 0; m_who = 0;
    m_op = 0; m_addr = 0; m_din = 0; m_dout = 0;
  endtask

  task automatic m_step();
    int  old_debt;
    bit  wrap, done;
    old_debt = m_debt;
    done     = (m_phase == 2) && (m_who == 1) && (mem_ready === 1'b1);
    wrap     = (m_cnt == RI - 1);
    m_cnt    = wrap ? 0 : m_cnt + 1;
    if (wrap && !done) m_debt = (m_debt < 15) ? m_debt + 1 : 15;
    else if (done && !wrap && m_debt > 0) m_debt = m_debt - 1;
    case (m_phase)
      0: begin
        m_who = 0;
        if (old_debt >= DMAX)  m_who = 1;
        else if (dl_req)       m_who = 2;
        else if (cpu_req)      m_who = 3;
        else if (old_debt > 0) m_who = 1;
        if (m_who == 1) begin m_op = 2; m_addr = 0; m_din = 0; end
        if (m_who == 2) begin m_op = 1; m_addr = int'(dl_addr); m_din = int'(dl_data); end
        if (m_who == 3) begin
          m_op = cpu_we ? 1 : 0; m_addr = int'(cpu_addr); m_din = int'(cpu_din);
        end
        if (m_who != 0) m_phase = 1;
      end
      1: m_phase = 2;
      2: if (mem_ready) begin
        if (m_who == 3 && m_op == 0) m_dout = int'(mem_dout);
        m_phase = 3;
      end
      default: m_phase = 0;
    endcase
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) m_reset();
      else m_step();
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("mem_req", mem_req, (m_phase == 1));
      chk("dl_ack", dl_ack, (m_phase == 3 && m_who == 2));
      chk("cpu_ack", cpu_ack, (m_phase == 3 && m_who == 3));
      chk("cpu_dout", cpu_dout, m_dout);
      chk("refresh_debt", refresh_debt, m_debt);
      if (m_phase == 1 || m_phase == 2) begin
        chk("mem_op", mem_op, m_op);
        chk("mem_addr", mem_addr, m_addr);
        if (m_op == 1) chk("mem_din", mem_din, m_din);
      end
    end
  end

  // Log of issued commands for ordering checks.
  int log_op[$], log_addr[$], log_din[$], log_debt[$];
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        log_op.push_back(int'(mem_op));
        log_addr.push_back(int'(mem_addr));
        log_din.push_back(int'(mem_din));
        log_debt.push_back(int'(refresh_debt));
      end
    end
  end

  // ---------------- emulated SDRAM controller ----------------
  int r_lat = 1;          // 0 = random 1..4
  bit r_hold = 0;         // stall completion while set
  bit r_fix_en = 0;
  int r_fix_data = 0;
  int stray_req = 0;
  int stray_seen = 0;
  bit pend;
  int r_cnt, r_data;

  initial begin
    mem_ready = 1'b0;
    mem_dout  = 8'h00;
    pend      = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      if (!reset_n) begin
        pend = 1'b0;
      end else begin
        if (pend && !r_hold) begin
          r_cnt--;
          if (r_cnt <= 0) begin
            mem_ready = 1'b1;
            mem_dout  = r_data[7:0];
            pend      = 1'b0;
          end
        end
        if (stray_req != stray_seen) begin
          mem_ready  = 1'b1;
          stray_seen = stray_req;
        end
        if (mem_req) begin
          pend   = 1'b1;
          r_cnt  = (r_lat != 0) ? r_lat : int'($urandom_range(1, 4));
          r_data = r_fix_en ? r_fix_data : int'($urandom_range(0, 255));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  int  req_i, rdy_i, ack_i, seen_op, seen_addr, start, max_debt, first_ref;
  bit  found, any_ack;

  initial begin
    reset_n = 1'b1;
    dl_req = 0; cpu_req = 0; cpu_we = 0;
    dl_addr = '0; cpu_addr = '0; dl_data = '0; cpu_din = '0;
    #2 reset_n = 1'b0;
    tick(); tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_dl_ack", dl_ack, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_cpu_dout", cpu_dout, 0);
    chk("rst_mem_op", mem_op, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_debt", refresh_debt, 0);
    reset_n = 1'b1;

    // Idle refresh: debt 1 after 390 cycles, refresh command next cycle.
    repeat (RI) tick();
    chk("t1_debt", refresh_debt, 1);
    chk("t1_no_req_yet", mem_req, 0);
    tick();
    chk("t1_req", mem_req, 1);
    chk("t1_op", mem_op, 2);
    chk("t1_addr", mem_addr, 0);
    tick(); tick();
    chk("t1_debt_paid", refresh_debt, 0);
    chk("t1_no_dl_ack", dl_ack, 0);
    chk("t1_no_cpu_ack", cpu_ack, 0);
    tick();

    // CPU read, 3-cycle controller returning 0xA5.
    r_lat = 3; r_fix_en = 1; r_fix_data = 'hA5;
    cpu_req = 1; cpu_we = 0; cpu_addr = 25'h001000;
    req_i = -1; rdy_i = -1; ack_i = -1; seen_op = -1; seen_addr = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (mem_req && req_i < 0) begin req_i = i; seen_op = mem_op; seen_addr = mem_addr; end
      if (mem_ready && rdy_i < 0) rdy_i = i;
      if (cpu_ack) begin
        ack_i = i;
        cpu_req = 0;
        chk("t2_dout_at_ack", cpu_dout, 'hA5);
        break;
      end
    end
    chk("t2_req_lat", req_i, 0);
    chk("t2_op", seen_op, 0);
    chk("t2_addr", seen_addr, 'h1000);
    chk("t2_ack_lat", ack_i, 4);
    chk("t2_ack_after_ready", ack_i - rdy_i, 1);
    repeat (5) tick();
    chk("t2_dout_held", cpu_dout, 'hA5);
    r_fix_en = 0; r_lat = 1;

    // Stall a refresh until debt is 3, then raise download and CPU together.
    r_hold = 1;
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin tick(); found = mem_req && mem_op == 2; end
    chk("t3_ref_issued", found, 1);
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin tick(); found = (refresh_debt == 3); end
    chk("t3_debt3", found, 1);
    dl_req = 1; dl_addr = 25'h010000; dl_data = 8'h3C;
    cpu_req = 1; cpu_we = 1; cpu_addr = 25'h002345; cpu_din = 8'h5A;
    start = log_op.size();
    r_hold = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (dl_ack) dl_req = 0;
      if (cpu_ack) cpu_req = 0;
    end
    chk("t3_count", log_op.size() - start, 4);
    if (log_op.size() - start == 4) begin
      chk("t3_dl_op", log_op[start], 1);
      chk("t3_dl_addr", log_addr[start], 'h10000);
      chk("t3_dl_din", log_din[start], 'h3C);
      chk("t3_cpu_op", log_op[start+1], 1);
      chk("t3_cpu_addr", log_addr[start+1], 'h2345);
      chk("t3_ref_a", log_op[start+2], 2);
      chk("t3_ref_b", log_op[start+3], 2);
    end
    chk("t3_debt_end", refresh_debt, 0);

    // Sustained download: refresh must preempt once debt reaches DEBT_MAX.
    r_lat = 0;
    dl_req = 1; dl_addr = 25'h1ABCDE; dl_data = 8'h77;
    start = log_op.size();
    max_debt = 0;
    for (int i = 0; i < 8 * RI + 400; i++) begin
      tick();
      if (int'(refresh_debt) > max_debt) max_debt = int'(refresh_debt);
    end
    dl_req = 0;
    first_ref = -1;
    for (int i = start; i < log_op.size(); i++)
      if (log_op[i] == 2 && first_ref < 0) first_ref = i;
    chk("t4_ref_seen", (first_ref >= 0), 1);
    if (first_ref >= 0) chk("t4_ref_at_max", (log_debt[first_ref] >= DMAX), 1);
    chk("t4_debt_reached_max", (max_debt >= DMAX), 1);
    chk("t4_debt_le9", (max_debt <= 9), 1);
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin tick(); found = (refresh_debt == 0) && !mem_req; end
    chk("t4_drained", found, 1);

    // Reset during WAIT of a CPU write, then a stray mem_ready.
    r_lat = 1; r_hold = 1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 25'h000777; cpu_din = 8'h11;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin tick(); found = mem_req && mem_op == 1; end
    chk("t5_write_issued", found, 1);
    tick(); tick();
    reset_n = 0; cpu_req = 0;
    any_ack = 0;
    repeat (2) begin
      tick();
      if (mem_req || cpu_ack || dl_ack) any_ack = 1;
    end
    reset_n = 1; r_hold = 0;
    tick();
    stray_req++;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_req || cpu_ack || dl_ack) any_ack = 1;
    end
    chk("t5_quiet", any_ack, 0);
    chk("t5_debt", refresh_debt, 0);

    // Interval wrap coincident with a refresh completion at debt 3.
    r_hold = 1; r_lat = 1;
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin tick(); found = mem_req && mem_op == 2; end
    chk("t6_ref_issued", found, 1);
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin tick(); found = (refresh_debt == 3); end
    chk("t6_debt3", found, 1);
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin tick(); found = (m_cnt == RI - 2); end
    r_hold = 0;
    tick();
    chk("t6_ready", mem_ready, 1);
    tick();
    chk("t6_debt_kept", refresh_debt, 3);
    repeat (40) tick();

    // Randomized traffic; address/data wander while a transaction is in flight.
    r_lat = 0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (dl_ack) dl_req = ($urandom_range(0, 3) == 0);
      else if (!dl_req) dl_req = ($urandom_range(0, 9) == 0);
      if (cpu_ack) cpu_req = ($urandom_range(0, 3) == 0);
      else if (!cpu_req) cpu_req = ($urandom_range(0, 2) == 0);
      cpu_we   = 1'($urandom_range(0, 1));
      cpu_addr = AW'($urandom);
      cpu_din  = 8'($urandom);
      dl_addr  = AW'($urandom);
      dl_data  = 8'($urandom);
    end
    dl_req = 0; cpu_req = 0;
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/c16_sdram_arb.md
Name: c16_sdram_arb

Overview:
Arbitrates the single SDRAM controller command port between three requesters: the ioctl ROM/PRG download writer, the C16 CPU/TED memory access, and periodic auto-refresh.
- Sits inside c16_guest, between the requesters and the SDRAM controller that drives the SDRAM_* pins.
- Guarantees refresh under sustained download or CPU load.
- Returns read data and a one-cycle ack to the winning requester.

Parameters:
ADDR_W, 25, SDRAM byte address width.
REFRESH_INTERVAL, 390, clk cycles between refresh debt increments (≈7.8 µs at 50 MHz).
DEBT_MAX, 8, refresh debt at which refresh preempts all other requesters.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
dl_req  in  1  download write request; level, held until dl_ack.
dl_addr  in  ADDR_W  download byte address.
dl_data  in  8  download write data.
dl_ack  out  1  one-cycle pulse when the download write has completed.
cpu_req  in  1  CPU/TED request; level, held until cpu_ack.
cpu_we  in  1  1 = write, 0 = read.
cpu_addr  in  ADDR_W  CPU/TED byte address.
cpu_din  in  8  CPU write data.
cpu_dout  out  8  read data; valid from the cpu_ack cycle, held until the next CPU read completes.
cpu_ack  out  1  one-cycle completion pulse.
mem_req  out  1  one-cycle command strobe to the SDRAM controller.
mem_op  out  2  0 = read, 1 = write, 2 = refresh, 3 = reserved (never issued).
mem_addr  out  ADDR_W  command address; 0 for refresh.
mem_din  out  8  write data to the controller.
mem_dout  in  8  read data from the controller.
mem_ready  in  1  one-cycle completion pulse from the controller.
refresh_debt  out  4  current refresh debt, for debug.

Behaviour:
- Reset (async, reset_n = 0):
  - state IDLE.
  - All outputs are 0: mem_req, dl_ack, cpu_ack, cpu_dout, mem_op, mem_addr, mem_din.
  - Interval counter is 0; debt is 0.
  - Asserting reset mid-transaction abandons that transaction. No ack is issued. Any late mem_ready arriving after reset is ignored in IDLE.
- Refresh interval counter:
  - Counts 0..REFRESH_INTERVAL-1 and wraps.
  - On wrap, debt increments, saturating at 15.
  - On a refresh completion (mem_ready while serving refresh), debt decrements.
  - Wrap and refresh completion in the same cycle leave debt unchanged.
- FSM states: IDLE, ISSUE, WAIT, ACK.
  - IDLE: selects a winner by priority and latches the winner, op, address and data.
    1. Refresh, if debt ≥ DEBT_MAX.
    2. Download, if dl_req.
    3. CPU, if cpu_req.
    4. Refresh, if debt > 0.
    - If there is no candidate, stay in IDLE.
  - ISSUE: mem_req = 1 for exactly one cycle with the latched mem_op, mem_addr and mem_din; go to WAIT.
  - WAIT: hold mem_op, mem_addr and mem_din stable. On mem_ready:
    - For a CPU read, latch mem_dout into cpu_dout.
    - Go to ACK.
    - mem_ready arriving in the ISSUE cycle itself is illegal; the controller latency is ≥ 1 cycle.
  - ACK: pulse dl_ack or cpu_ack for one cycle (nothing for refresh); return to IDLE.
- Latency:
  - Request in IDLE → mem_req is 1 cycle later.
  - mem_ready → ack is 1 cycle later.
  - Minimum request-to-ack with a 1-cycle controller is 4 cycles.
- Back-to-back: a requester holding req through the ACK cycle is re-arbitrated in the following IDLE cycle. Requesters must drop req in the ack cycle for a single access.
- Requests drop or change while in ISSUE, WAIT or ACK: the latched transaction completes unchanged.
- Simultaneous dl_req, cpu_req and debt > 0 below DEBT_MAX: download wins, then CPU, then refresh.
- No starvation guarantee for CPU during download; downloads occur only while the core is held in reset.
- Address width: addresses pass through unmodified; no wrap or masking.

Decomposition:
- Shared package c16_mem_pkg:
  - mem_op encoding constants (MEM_RD, MEM_WR, MEM_REF).
  - Arbiter state typedef.
  - Requester-select enum (SEL_NONE, SEL_REF, SEL_DL, SEL_CPU).
- One sub-module, c16_refresh_timer: interval counter and saturating debt counter. Inputs: clk, reset_n, refresh_done. Output: debt.

Test Plan:
- Reset then idle for 390 cycles → refresh_debt = 1; next cycle mem_req = 1 with mem_op = 2 and mem_addr = 0. After mem_ready → debt = 0, with no dl_ack or cpu_ack pulse.
- CPU read at 0x001000 with the controller returning 0xA5 after 3 cycles → mem_op = 0, mem_addr = 0x001000; cpu_ack 1 cycle after mem_ready; cpu_dout = 0xA5 and held afterwards.
- dl_req (0x010000, 0x3C) and cpu_req asserted in the same cycle with debt = 2 → download is served first (mem_op = 1, mem_din = 0x3C), then CPU, then 2 refreshes; debt ends at 0.
- dl_req held continuously for 8 × 390 cycles → when debt reaches 8, the next IDLE issues a refresh ahead of the pending download; debt never exceeds 9.
- reset_n pulsed low during WAIT of a CPU write → mem_req and cpu_ack stay 0; a stray mem_ready after reset release produces no ack; debt = 0.
- Interval wrap coincident with a refresh completion at debt = 3 → debt remains 3.
